// File: rtl/dmem_arb_defs.sv
// Shared definitions for the data-memory port arbiter: owner-state encoding,
// default starvation bound and the starvation counter width helper.
package dmem_arb_defs;

  // Which requester owned the memory port in the previous cycle
  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // Default number of consecutive denied host cycles before a forced grant
  localparam int unsigned DEF_STARVE_MAX = 8;

  // Counter width able to hold 0..max_val; at least one bit so max_val = 0 still elaborates
  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating host-starvation counter. Counts consecutive denied host cycles,
// saturates at STARVE_MAX and flags at_max once the bound is reached.
// STARVE_MAX = 0 makes at_max permanently true (host strict priority).
module dmem_arb_starve_ctr
  import dmem_arb_defs::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
  localparam int unsigned CNT_W = ctr_width(STARVE_MAX)
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CNT_W-1:0] count;

  generate
    if (STARVE_MAX == 0) begin : g_strict
      assign at_max = 1'b1;
    end else begin : g_bounded
      localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);
      assign at_max = (count >= MAX_C);
    end
  endgenerate

  // Clear wins over increment; increment stops at the bound
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and a host/debug
// requester. Pipeline has priority; host starvation is bounded by a saturating
// counter, and a forced host grant stalls the pipeline for one cycle.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter
  import dmem_arb_defs::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_rd,
  input  logic              pipe_wr,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_host_grants,
  output logic [31:0]       stat_stall_cycles
`endif
);

  logic   pipe_act;
  logic   at_max;
  owner_e owner_q;
  owner_e owner_d;
  logic   host_rd_q;

  assign pipe_act = pipe_rd | pipe_wr;

  // Grant depends only on current requests and registered starvation state
  assign host_gnt   = reset & host_req & (~pipe_act | at_max);
  assign pipe_stall = pipe_act & host_gnt;

  // Read data always comes straight from memory; it is meaningless while stalled
  assign pipe_rdata = mem_rdata;

  dmem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clock  (clock),
    .reset  (reset),
    .inc    (host_req & ~host_gnt),
    .clr    (host_gnt | ~host_req),
    .at_max (at_max)
  );

  // Memory port mux: host when granted, otherwise pipeline; silent in reset
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mem_addr  = pipe_addr;
    mem_wdata = pipe_wdata;
    mem_read  = pipe_rd & reset;
    mem_write = pipe_wr & reset;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_read  = ~host_we;
      mem_write = host_we;
    end
  end

  // Owner state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q <= OWN_PIPE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Owner next state: a host grant lasts one cycle and is re-arbitrated each cycle
  always_comb begin
    owner_d = OWN_PIPE;
    unique case (owner_q)
      OWN_PIPE: owner_d = host_gnt ? OWN_HOST : OWN_PIPE;
      OWN_HOST: owner_d = host_gnt ? OWN_HOST : OWN_PIPE;
      default:  owner_d = OWN_PIPE;
    endcase
  end

  // Capture host read data at the grant-cycle edge; hold it until the next host read
  always_ff @(posedge clock) begin
    if (!reset) begin
      host_rd_q  <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_rd_q <= host_gnt & ~host_we;
      if (host_gnt && !host_we) begin
        host_rdata <= mem_rdata;
      end
    end
  end

  // Gated by reset so a read granted just before reset never reports valid data
  assign host_rvalid = reset & (owner_q == OWN_HOST) & host_rd_q;

`ifdef DMEM_ARB_STATS_EN
  // Free-running grant and stall counters, wrapping at 2^32
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_host_grants  <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (host_gnt) begin
        stat_host_grants <= stat_host_grants + 32'd1;
      end
      if (pipe_stall) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter. Host read results are tracked in
// a scoreboard queue filled when a read grant is expected and drained by a
// monitor whenever host_rvalid is seen. A second instance with STARVE_MAX = 0
// covers host strict priority.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              pipe_rd = 1'b0;
  logic              pipe_wr = 1'b0;
  logic [ADDR_W-1:0] pipe_addr = '0;
  logic [DATA_W-1:0] pipe_wdata = '0;
  logic [DATA_W-1:0] pipe_rdata;
  logic              pipe_stall;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  // Outputs of the strict-priority instance
  logic [DATA_W-1:0] z_pipe_rdata;
  logic              z_pipe_stall;
  logic              z_host_gnt;
  logic              z_host_rvalid;
  logic [DATA_W-1:0] z_host_rdata;
  logic [ADDR_W-1:0] z_mem_addr;
  logic [DATA_W-1:0] z_mem_wdata;
  logic              z_mem_read;
  logic              z_mem_write;
  logic [DATA_W-1:0] z_mem_rdata = '0;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_host_grants;
  logic [31:0] stat_stall_cycles;
  logic [31:0] z_stat_host_grants;
  logic [31:0] z_stat_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;

  // Behavioural data memory: combinational read, write at the clock edge
  logic [DATA_W-1:0] mem_model [0:255];
  assign mem_rdata = mem_model[mem_addr[7:0]];
  always @(posedge clock) begin
    if (mem_write === 1'b1) mem_model[mem_addr[7:0]] <= mem_wdata;
  end

  always #5 clock = ~clock;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8)
  ) dut (
    .clock(clock), .reset(reset),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_host_grants(stat_host_grants), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(0)
  ) dut0 (
    .clock(clock), .reset(reset),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(z_pipe_rdata), .pipe_stall(z_pipe_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(z_host_gnt), .host_rvalid(z_host_rvalid),
    .host_rdata(z_host_rdata), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_rdata(z_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_host_grants(z_stat_host_grants), .stat_stall_cycles(z_stat_stall_cycles)
`endif
  );

  // Scoreboard monitor: every host_rvalid must match the oldest expected read
  always @(negedge clock) begin
    if (host_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: host_rdata=%h but no host read outstanding", host_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (host_rdata !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard_rdata: got %h expected %h", host_rdata, mon_exp);
        end
      end
    end
  end

  task automatic idle_inputs();
    pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pipe_rd = 1'b1; pipe_wr = 1'b1; pipe_addr = 64'h10;
    host_req = 1'b1; host_we = 1'b1; host_addr = 64'h40; host_wdata = 64'h1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", host_gnt); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", pipe_stall); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", host_rvalid); end
    checks++; if (host_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", host_rdata); end
    checks++; if (z_host_gnt !== 1'b0) begin errors++; $display("FAIL reset_strict_gnt: got %b expected 0", z_host_gnt); end
    next_cycle();
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_host_rw();
    next_cycle();
    host_req = 1'b1; host_we = 1'b1; host_addr = 64'h40; host_wdata = 64'hDEAD_BEEF;
    @(negedge clock);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL host_wr_gnt: got %b expected 1", host_gnt); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL host_wr_stall: got %b expected 0", pipe_stall); end
    checks++; if ({mem_write, mem_read} !== 2'b10) begin errors++; $display("FAIL host_wr_strobes: got %b expected 10", {mem_write, mem_read}); end
    checks++; if (mem_addr !== 64'h40) begin errors++; $display("FAIL host_wr_addr: got %h expected 40", mem_addr); end
    checks++; if (mem_wdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL host_wr_data: got %h expected deadbeef", mem_wdata); end
    next_cycle();
    host_we = 1'b0;
    @(negedge clock);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL host_rd_gnt: got %b expected 1", host_gnt); end
    checks++; if ({mem_write, mem_read} !== 2'b01) begin errors++; $display("FAIL host_rd_strobes: got %b expected 01", {mem_write, mem_read}); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL host_rd_early_valid: got %b expected 0", host_rvalid); end
    exp_q.push_back(64'hDEAD_BEEF);
    next_cycle();
    host_req = 1'b0;
    @(negedge clock);
    checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL host_rd_valid: got %b expected 1", host_rvalid); end
    checks++; if (host_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL host_rd_data: got %h expected deadbeef", host_rdata); end
    next_cycle();
    @(negedge clock);
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL host_rd_valid_drop: got %b expected 0", host_rvalid); end
    checks++; if (host_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL host_rd_hold: got %h expected deadbeef", host_rdata); end
  endtask

  task automatic test_forced_grant();
    logic exp_g;
    next_cycle();
    pipe_rd = 1'b1; pipe_addr = 64'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 64'h40;
    for (int c = 0; c < 10; c++) begin
      exp_g = (c == 8);
      @(negedge clock);
      checks++; if (host_gnt !== exp_g) begin errors++; $display("FAIL forced_gnt c%0d: got %b expected %b", c, host_gnt, exp_g); end
      checks++; if (pipe_stall !== exp_g) begin errors++; $display("FAIL forced_stall c%0d: got %b expected %b", c, pipe_stall, exp_g); end
      checks++;
      if (exp_g) begin
        exp_q.push_back(64'hDEAD_BEEF);
        if (mem_addr !== 64'h40 || mem_read !== 1'b1) begin errors++; $display("FAIL forced_host_port c%0d: got addr %h rd %b expected addr 40 rd 1", c, mem_addr, mem_read); end
      end else begin
        if (mem_addr !== 64'h10 || mem_read !== 1'b1) begin errors++; $display("FAIL forced_pipe_port c%0d: got addr %h rd %b expected addr 10 rd 1", c, mem_addr, mem_read); end
      end
      if (c < 9) next_cycle();
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    next_cycle();
    pipe_wr = 1'b1; pipe_addr = 64'h8; pipe_wdata = 64'h11;
    host_req = 1'b1; host_we = 1'b0; host_addr = 64'h8;
    @(negedge clock);
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL same_gnt: got %b expected 0", host_gnt); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL same_stall: got %b expected 0", pipe_stall); end
    checks++; if (mem_write !== 1'b1 || mem_addr !== 64'h8 || mem_wdata !== 64'h11) begin errors++; $display("FAIL same_pipe_store: got we %b addr %h data %h expected 1 8 11", mem_write, mem_addr, mem_wdata); end
    next_cycle();
    pipe_wr = 1'b0;
    @(negedge clock);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL same_host_gnt: got %b expected 1", host_gnt); end
    checks++; if (mem_read !== 1'b1 || mem_addr !== 64'h8) begin errors++; $display("FAIL same_host_port: got rd %b addr %h expected 1 8", mem_read, mem_addr); end
    exp_q.push_back(64'h11);
    next_cycle();
    host_req = 1'b0;
    pipe_rd = 1'b1; pipe_addr = 64'h8;
    @(negedge clock);
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 64'h11) begin errors++; $display("FAIL same_host_rdata: got v %b data %h expected 1 11", host_rvalid, host_rdata); end
    checks++; if (pipe_rdata !== 64'h11) begin errors++; $display("FAIL pipe_load_passthru: got %h expected 11", pipe_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_host_drop();
    next_cycle();
    pipe_rd = 1'b1; pipe_addr = 64'h10;
    host_req = 1'b1; host_we = 1'b1; host_addr = 64'h20; host_wdata = 64'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (host_gnt !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL drop_denied c%0d: got gnt %b we %b expected 0 0", c, host_gnt, mem_write); end
      next_cycle();
    end
    host_req = 1'b0;
    @(negedge clock);
    checks++; if (dut.u_starve_ctr.count !== 4'd3) begin errors++; $display("FAIL drop_count: got %0d expected 3", dut.u_starve_ctr.count); end
    next_cycle();
    host_req = 1'b1;
    @(negedge clock);
    checks++; if (dut.u_starve_ctr.count !== 4'd0) begin errors++; $display("FAIL drop_clear: got %0d expected 0", dut.u_starve_ctr.count); end
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL drop_regnt: got %b expected 0", host_gnt); end
    next_cycle();
    host_req = 1'b0; pipe_addr = 64'h20;
    @(negedge clock);
    checks++; if (pipe_rdata !== 64'h0) begin errors++; $display("FAIL drop_no_write: got %h expected 0", pipe_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_strict_priority();
    next_cycle();
    pipe_rd = 1'b1; pipe_addr = 64'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 64'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (z_host_gnt !== 1'b1 || z_pipe_stall !== 1'b1) begin errors++; $display("FAIL strict c%0d: got gnt %b stall %b expected 1 1", c, z_host_gnt, z_pipe_stall); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    host_req = 1'b1; host_we = 1'b0; host_addr = 64'h40;
    @(negedge clock);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt: got %b expected 1", host_gnt); end
    next_cycle();
    host_req = 1'b0; reset = 1'b0;
    pipe_wr = 1'b1; pipe_addr = 64'h30;
    @(negedge clock);
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b expected 0", host_rvalid); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL mid_mem_write: got %b expected 0", mem_write); end
    next_cycle();
    @(negedge clock);
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid2: got %b expected 0", host_rvalid); end
    checks++; if (host_rdata !== 64'h0) begin errors++; $display("FAIL mid_rdata: got %h expected 0", host_rdata); end
    checks++; if (dut.u_starve_ctr.count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", dut.u_starve_ctr.count); end
    next_cycle();
    idle_inputs();
    reset = 1'b1;
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    pipe_rd = 1'b1; pipe_addr = 64'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 64'h40;
    for (int c = 0; c < 27; c++) begin
      @(negedge clock);
      if (c % 9 == 8) exp_q.push_back(64'hDEAD_BEEF);
      next_cycle();
    end
    idle_inputs();
    @(negedge clock);
    checks++; if (stat_host_grants !== 32'd3) begin errors++; $display("FAIL stat_grants: got %0d expected 3", stat_host_grants); end
    checks++; if (stat_stall_cycles !== 32'd3) begin errors++; $display("FAIL stat_stalls: got %0d expected 3", stat_stall_cycles); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    test_reset();
    test_host_rw();
    test_forced_grant();
    test_same_cycle();
    test_host_drop();
    test_strict_priority();
    test_reset_mid();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    next_cycle();
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d reads outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data memory port between the pipeline MEM stage (EX/MEM register outputs) and an external host/debug requester used for program loading and memory inspection. The pipeline has priority, but host starvation is bounded by a saturating wait counter. When that counter forces a host grant, the arbiter stalls the pipeline for exactly one cycle. The block sits between the EX/MEM register and the data memory; its read-data path feeds the MEM/WB register unchanged.

## Interface
Parameters:
- ADDR_W, 64, address width of both requesters and memory
- DATA_W, 64, data width
- STARVE_MAX, 8, number of consecutive denied host cycles before a forced host grant; 0 = host strict priority

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- pipe_rd  in  1  EX/MEM MemRead
- pipe_wr  in  1  EX/MEM MemWrite
- pipe_addr  in  ADDR_W  EX/MEM ALU result
- pipe_wdata  in  DATA_W  EX/MEM store data
- pipe_rdata  out  DATA_W  read data to MEM/WB
- pipe_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- host_req  in  1  host access request, held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_rdata  in  DATA_W  from data memory (combinational read)

## Operation
- pipe_act = pipe_rd | pipe_wr.
- Grant is combinational from registered state: host_gnt = reset & host_req & (!pipe_act | starve_cnt >= STARVE_MAX).
- pipe_stall = pipe_act & host_gnt.
- Memory mux:
  - host_gnt: mem_* driven from host_* (mem_read = !host_we, mem_write = host_we).
  - Otherwise: mem_* driven from pipe_*.
  - During reset low: mem_read = mem_write = 0.
- pipe_rdata = mem_rdata whenever the pipeline owns the port. Its value is don't-care while pipe_stall is high.
- Starvation counter starve_cnt, width clog2(STARVE_MAX+1):
  - increment (saturating at STARVE_MAX) when host_req & !host_gnt
  - clear to 0 on host_gnt or !host_req
- Two-state owner FSM, registered:
  - OWN_PIPE → OWN_HOST when host_gnt.
  - OWN_HOST → OWN_PIPE otherwise.
  - OWN_HOST lasts one cycle per grant; a held host_req is re-arbitrated every cycle.
- Host read return:
  - A host read granted in cycle N gives host_rvalid = 1 and host_rdata = mem_rdata sampled in cycle N, both in cycle N+1.
  - host_rdata holds its value until the next host read.

## Timing
- Reset (reset low at a clock edge): starve_cnt = 0, FSM = OWN_PIPE, host_rvalid = 0, host_rdata = 0. Combinationally while reset is low: host_gnt = 0, pipe_stall = 0.
- Pipeline access latency: 0 cycles (pass-through). Host write: committed at the grant-cycle edge. Host read: 1 cycle to host_rvalid.
- Forced grant (pipe_act continuously high): host_req rising in cycle 0 gives host_gnt and pipe_stall in cycle STARVE_MAX, then host denied again in cycle STARVE_MAX+1.
- Pipeline stalled by a forced grant retries the same access the next cycle, which the pipeline always wins because starve_cnt = 0.
- host_req dropped before grant: counter clears; no access.
- Reset asserted mid-operation: a host read granted in the cycle before reset produces no host_rvalid.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - adds outputs stat_host_grants (32b) and stat_stall_cycles (32b), counting host_gnt cycles and pipe_stall cycles
  - both counters wrap at 2^32 and clear on reset
- DMEM_ARB_STATS_EN undefined: those ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Shared package/header dmem_arb_defs:
  - owner-state encodings OWN_PIPE = 1'b0, OWN_HOST = 1'b1
  - default STARVE_MAX constant
- One sub-module, dmem_arb_starve_ctr: saturating counter with inputs inc, clr and output at_max.
- Memory mux and grant logic live in the top module.

## Test plan
- Host only, write 0xDEAD_BEEF to address 0x40, then read 0x40: host_gnt each request cycle; host_rvalid one cycle after the read grant with host_rdata = 0xDEAD_BEEF.
- Pipe load every cycle with host_req held, STARVE_MAX = 8: host_gnt and pipe_stall high exactly in cycle 8 and low in cycles 0–7 and 9; pipe load repeated in cycle 9.
- Same cycle: pipe store 0x11 to 0x8 and host read of 0x8 with starve_cnt < STARVE_MAX: pipe wins with no stall; host granted the next cycle (pipe idle) and reads 0x11.
- STARVE_MAX = 0 with pipe_act high and host_req high: host_gnt = 1 and pipe_stall = 1 in every cycle.
- Reset pulled low the cycle after a host read grant: host_rvalid stays 0, starve_cnt = 0, mem_write = 0 while reset is low.
- With DMEM_ARB_STATS_EN, run scenario 2 for 27 cycles: stat_host_grants = 3, stat_stall_cycles = 3.
